// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronises cs/sclk/sda into clk, shifts DATA_W-bit
// MSB-first words on sclk falling edges and hands them out on a valid/ack
// port with sticky overrun and a frame_err pulse for discarded partial words.
// Optional macro SPI_RX_TIMEOUT_EN adds an idle-cycle timeout mid-word.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk,
  input  logic              sda,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              overrun,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W + 1);

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("spi_slave_rx: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cs_sr, sclk_sr, sda_sr;
  logic                   cs_s, sclk_s, sda_s, sclk_prev, fall;
  logic [DATA_W-1:0]      shift, shift_n, data_n;
  logic [CW-1:0]          bit_cnt, cnt_n;
  logic                   valid_n, busy_n, ovr_n, ferr_n;
  logic                   done, abort;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] idle_cnt, idle_n;
`endif

  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign sda_s  = sda_sr[SYNC_STAGES-1];
  assign fall   = sclk_prev & ~sclk_s;

  // Equal-depth synchronisers keep cs/sclk/sda mutually aligned; reset to idle line levels
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_sr     <= '1;
      sclk_sr   <= '1;
      sda_sr    <= '0;
      sclk_prev <= 1'b1;
    end else begin
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs};
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      sda_sr    <= {sda_sr[SYNC_STAGES-2:0], sda};
      sclk_prev <= sclk_s;
    end
  end

  // Next-state logic: shifting, word completion/abort, then the output handshake
  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = bit_cnt;
    data_n  = data_out;
    busy_n  = rx_busy;
    ferr_n  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
    idle_n  = '0;
`endif
    case (state)
      IDLE: begin
        if (!cs_s && fall) begin
          shift_n = {{(DATA_W-1){1'b0}}, sda_s};
          cnt_n   = CW'(1);
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // completion has priority over a simultaneous cs deassertion
        if (fall) begin
          shift_n = {shift[DATA_W-2:0], sda_s};
          if (bit_cnt == CW'(DATA_W - 1)) done = 1'b1;
          else cnt_n = bit_cnt + CW'(1);
        end else if (cs_s) begin
          abort = 1'b1;
        end
`ifdef SPI_RX_TIMEOUT_EN
        else begin
          // saturating idle count; reaching the limit discards the word
          idle_n = (idle_cnt == IW'(TIMEOUT_CYC)) ? idle_cnt : idle_cnt + IW'(1);
          if (idle_n == IW'(TIMEOUT_CYC)) abort = 1'b1;
        end
`endif
        if (done) begin
          data_n  = shift_n;
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
        if (abort) begin
          shift_n = '0;
          cnt_n   = '0;
          busy_n  = 1'b0;
          ferr_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    valid_n = rx_valid;
    ovr_n   = overrun;
    if (rx_valid && rx_ack) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end
    if (done) begin
      valid_n = 1'b1;
      if (rx_valid && !rx_ack) ovr_n = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      bit_cnt   <= cnt_n;
      data_out  <= data_n;
      rx_valid  <= valid_n;
      rx_busy   <= busy_n;
      overrun   <= ovr_n;
      frame_err <= ferr_n;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt  <= idle_n;
`endif
    end
  end
endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: a bit-banging SPI master plus a
// word-level model of data_out/rx_valid/overrun.
module tb_spi_slave_rx;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b0, cs = 1'b1, sclk = 1'b1, sda = 1'b0, rx_ack = 1'b0;
  logic [DW-1:0] data_out;
  logic          rx_valid, rx_busy, overrun, frame_err;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;

  // word-level reference state
  logic [DW-1:0] exp_data = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ovr = 1'b0;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .sda(sda), .rx_ack(rx_ack),
    .data_out(data_out), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .overrun(overrun), .frame_err(frame_err)
  );

  // count cycles with frame_err high
  always @(negedge clk) if (frame_err) ferr_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // a completed word: overwrite, and overrun if previous one still pending
  task automatic model_word(input logic [DW-1:0] w);
    if (exp_valid) exp_ovr = 1'b1;
    exp_data  = w;
    exp_valid = 1'b1;
  endtask

  task automatic do_ack();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // MSB-first; data changes while sclk high, sampled at the falling edge
  task automatic send_bits(input logic [DW-1:0] w, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      sda = w[DW-1-i];
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      repeat (half) @(negedge clk);
      sclk = 1'b1;
    end
  endtask

  task automatic start_frame(input int half);
    @(negedge clk) cs = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, rx_valid, rx_busy, overrun, frame_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b%b%b%b want all zero", data_out, rx_valid, rx_busy, overrun, frame_err);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [DW-1:0] w;
    int n;
    w = 8'hA5;
    start_frame(65);
    send_bits(w, 7, 65);
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b want 1", rx_busy); end
    sda = w[0];
    repeat (65) @(negedge clk);
    sclk = 1'b0;
    n = 0;
    while (!rx_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != SS + 1) begin errors++; $display("FAIL basic_latency: got %0d cycles want %0d", n, SS + 1); end
    repeat (65) @(negedge clk);
    sclk = 1'b1;
    model_word(w);
    repeat (2) @(negedge clk);
    checks++;
    if (data_out !== exp_data || rx_valid !== 1'b1) begin
      errors++; $display("FAIL basic_data: got %h v=%b want %h v=1", data_out, rx_valid, exp_data);
    end
    checks++;
    if (rx_busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL basic_flags: got busy=%b ovr=%b want 0 0", rx_busy, overrun);
    end
    end_frame();
    do_ack();
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int n;
    start_frame(12);
    fork
      begin
        send_bits(8'h3C, 8, 12);
        send_bits(8'hC3, 8, 12);
      end
      begin
        n = 0;
        while (!rx_valid && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (n >= 400 || data_out !== 8'h3C) begin
          errors++; $display("FAIL b2b_first: got %h after %0d cycles want 3c", data_out, n);
        end
        rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
      end
    join
    exp_data = 8'hC3; exp_valid = 1'b1; exp_ovr = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (data_out !== exp_data || rx_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got %h v=%b o=%b want c3 v=1 o=0", data_out, rx_valid, overrun);
    end
    end_frame();
    do_ack();
  endtask

  task automatic test_overrun();
    start_frame(10);
    send_bits(8'h11, 8, 10);
    model_word(8'h11);
    repeat (4) @(negedge clk);
    checks++;
    if (overrun !== exp_ovr || data_out !== exp_data) begin
      errors++; $display("FAIL ovr_first: got %h o=%b want %h o=%b", data_out, overrun, exp_data, exp_ovr);
    end
    send_bits(8'h22, 8, 10);
    model_word(8'h22);
    repeat (4) @(negedge clk);
    checks++;
    if (data_out !== exp_data || rx_valid !== exp_valid || overrun !== exp_ovr) begin
      errors++; $display("FAIL ovr_second: got %h v=%b o=%b want %h v=%b o=%b", data_out, rx_valid, overrun, exp_data, exp_valid, exp_ovr);
    end
    end_frame();
    do_ack();
    checks++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got v=%b o=%b want 0 0", rx_valid, overrun);
    end
  endtask

  task automatic test_frame_err();
    start_frame(9);
    send_bits(8'hF0, 4, 9);
    ferr_cnt = 0;
    cs = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles high want 1", ferr_cnt); end
    checks++;
    if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      errors++; $display("FAIL ferr_flags: got v=%b busy=%b want 0 0", rx_valid, rx_busy);
    end
    start_frame(9);
    send_bits(8'h5A, 8, 9);
    model_word(8'h5A);
    repeat (4) @(negedge clk);
    checks++;
    if (data_out !== exp_data || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ferr_next: got %h v=%b want %h v=1", data_out, rx_valid, exp_data);
    end
    end_frame();
    do_ack();
  endtask

  task automatic test_reset_midword();
    start_frame(8);
    send_bits(8'hFF, 5, 8);
    ferr_cnt = 0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    checks++;
    if ({data_out, rx_valid, rx_busy, overrun, frame_err} !== '0) begin
      errors++; $display("FAIL rst_mid_state: got %h/%b%b%b%b want all zero", data_out, rx_valid, rx_busy, overrun, frame_err);
    end
    exp_data = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (ferr_cnt != 0) begin errors++; $display("FAIL rst_mid_ferr: got %0d want 0", ferr_cnt); end
    send_bits(8'h07, 8, 8);
    model_word(8'h07);
    repeat (4) @(negedge clk);
    checks++;
    if (data_out !== exp_data || rx_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL rst_mid_next: got %h v=%b o=%b want 07 v=1 o=0", data_out, rx_valid, overrun);
    end
    end_frame();
    do_ack();
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    int h;
    for (int k = 0; k < 16; k++) begin
      h = $urandom_range(8, 20);
      w = DW'($urandom);
      if (cs) start_frame(h);
      send_bits(w, 8, h);
      model_word(w);
      repeat (4) @(negedge clk);
      checks++;
      if (data_out !== exp_data || rx_valid !== exp_valid || overrun !== exp_ovr) begin
        errors++; $display("FAIL rand_word%0d: got %h v=%b o=%b want %h v=%b o=%b", k, data_out, rx_valid, overrun, exp_data, exp_valid, exp_ovr);
      end
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        if ($urandom_range(0, 1) == 1) do_ack();  // ack with nothing pending
        checks++;
        if (rx_valid !== exp_valid || overrun !== exp_ovr) begin
          errors++; $display("FAIL rand_ack%0d: got v=%b o=%b want 0 0", k, rx_valid, overrun);
        end
      end
      if ($urandom_range(0, 2) == 0) end_frame();
    end
    end_frame();
    do_ack();
  endtask

`ifdef SPI_RX_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    start_frame(10);
    send_bits(8'hA0, 2, 10);
    sda = 1'b1;
    repeat (10) @(negedge clk);
    sclk = 1'b0;
    fork
      begin repeat (10) @(negedge clk); sclk = 1'b1; end
    join_none
    n = 0;
    while (!frame_err && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != TO + SS + 1) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", n, TO + SS + 1); end
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL timeout_flags: got busy=%b v=%b ferr=%b want 0 0 0", rx_busy, rx_valid, frame_err);
    end
    send_bits(8'h81, 8, 10);
    model_word(8'h81);
    repeat (4) @(negedge clk);
    checks++;
    if (data_out !== exp_data || rx_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_next: got %h v=%b want 81 v=1", data_out, rx_valid);
    end
    end_frame();
    do_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_midword();
    test_random();
`ifdef SPI_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI slave receiver at the far end of the team's SPI master transmitter.
- Samples the serial line (cs, sclk, sda) in the system clock domain, deserialises 8-bit MSB-first words and presents each completed word on a parallel output.
- Output uses a valid/ack handshake with overrun detection.
- Target serial timing: sclk idle high; data changes on sclk rising edge; data sampled on sclk falling edge; minimum half-period 8 clk cycles.

Parameters:
- DATA_W, 8, bits per word; shifted MSB first.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on cs, sclk and sda; must be ≥2.
- TIMEOUT_CYC, 1024, idle clk cycles mid-word before the partial word is discarded (used only with SPI_RX_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- cs  input  1  chip select from master, active low, asynchronous to clk
- sclk  input  1  serial clock from master, idle high, asynchronous to clk
- sda  input  1  serial data from master, asynchronous to clk
- rx_ack  input  1  consumer acknowledge; clears rx_valid
- data_out  output  DATA_W  last completed word
- rx_valid  output  1  level: data_out holds an unacknowledged word
- rx_busy  output  1  high while a word is partially received
- overrun  output  1  a word completed while the previous one was unacknowledged
- frame_err  output  1  one-cycle pulse when a partial word is discarded

Behaviour:
- Reset (reset==0 at a clk edge): all outputs 0; bit counter 0; shift register 0; synchronisers loaded with idle values (cs=1, sclk=1, sda=0); FSM to IDLE. Reset applied mid-word discards the word with no frame_err.
- Synchronisation: cs, sclk and sda each pass through SYNC_STAGES flops of equal depth, so they stay mutually aligned. A falling edge is detected when the previous synced sclk was 1 and the current one is 0.
- FSM IDLE:
  - Synced cs==0 and a falling edge: shift in synced sda, bit_cnt=1, rx_busy=1, go to SHIFT.
  - Synced cs==1: falling edges are ignored.
- FSM SHIFT:
  - Each falling edge: shift register <= {shift[DATA_W-2:0], sda_sync}; bit_cnt+1.
  - On the DATA_W-th edge: next cycle data_out = assembled word, rx_valid=1, rx_busy=0, bit_cnt=0, back to IDLE. Latency from the final detected falling edge to rx_valid is 1 clk.
  - Synced cs rising mid-word: discard partial word, frame_err pulse 1 cycle, rx_busy=0, go to IDLE.
- Back-to-back words with cs held low are legal; no gap is required between words.
- Handshake:
  - rx_valid stays high until a cycle with rx_ack==1, then clears on the next edge.
  - rx_ack while rx_valid==0 is ignored.
- Overrun:
  - Word completes while rx_valid==1 and rx_ack==0: data_out is overwritten with the new word, rx_valid stays 1, overrun sets.
  - overrun is sticky; it clears on the edge after rx_ack.
  - Completion and rx_ack in the same cycle: the new word is loaded, rx_valid stays 1, overrun is not set.
- Completion and cs rising in the same cycle: completion wins; the word is delivered and no frame_err is raised.
- sda activity without sclk edges has no effect.

Optional Feature:
- SPI_RX_TIMEOUT_EN defined:
  - In SHIFT, an idle counter counts clk cycles since the last falling edge and resets on each edge.
  - Counter width ceil(log2(TIMEOUT_CYC+1)); it saturates and does not wrap.
  - On reaching TIMEOUT_CYC: discard partial word, frame_err pulse, go to IDLE.
  - Needed because the master may hold cs low permanently, leaving no cs-based resynchronisation.
- Undefined: no idle counter; only cs deassertion aborts a partial word.

Test Plan:
- Master sends 0xA5, cs low, half-period 65 clk -> data_out=0xA5 and rx_valid=1 one clk after the 8th detected falling edge; rx_busy low afterwards.
- Send 0x3C then 0xC3 back-to-back with rx_ack pulsed after the first -> data_out 0x3C then 0xC3; overrun stays 0.
- Send 0x11 then 0x22 with no rx_ack -> data_out=0x22, rx_valid=1, overrun=1; one rx_ack clears rx_valid and overrun.
- Send 4 bits of 0xF0, then raise cs -> frame_err one-cycle pulse, rx_valid stays 0; a following full 0x5A is received correctly.
- With SPI_RX_TIMEOUT_EN, TIMEOUT_CYC=200: stop sclk after 3 bits -> frame_err 200 clk after the last edge; a subsequent 0x81 is received intact.
- Assert reset for 1 cycle mid-word (bit 5 of 0xFF) -> all outputs 0, no frame_err; the next word 0x07 is received correctly.
